// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units and the CDB writeback arbiter.
// The master side is the functional-unit side; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter type T      = logic [31:0],
    parameter int  N_FU   = 3,
    parameter int  PREG_W = 7,
    parameter int  ROB_W  = 4
);
    localparam int SRC_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int DATA_W = $bits(T);

    logic [N_FU-1:0]              req_valid;
    logic [N_FU-1:0]              req_ready;
    logic [N_FU-1:0][PREG_W-1:0]  req_prd;
    logic [N_FU-1:0][ROB_W-1:0]   req_rob_tag;
    logic [N_FU-1:0][DATA_W-1:0]  req_data;
    logic [N_FU-1:0]              req_regwrite;

    logic                         cdb_valid;
    logic [PREG_W-1:0]            cdb_prd;
    logic [ROB_W-1:0]             cdb_rob_tag;
    T                             cdb_data;
    logic                         cdb_regwrite;
    logic [SRC_W-1:0]             cdb_src;
    logic [N_FU-1:0][15:0]        grant_count;

    modport master (
        output req_valid, req_prd, req_rob_tag, req_data, req_regwrite,
        input  req_ready,
        input  cdb_valid, cdb_prd, cdb_rob_tag, cdb_data, cdb_regwrite, cdb_src,
        input  grant_count
    );

    modport slave (
        input  req_valid, req_prd, req_rob_tag, req_data, req_regwrite,
        output req_ready,
        output cdb_valid, cdb_prd, cdb_rob_tag, cdb_data, cdb_regwrite, cdb_src,
        output grant_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter onto the common data bus, one broadcast per
// cycle, with flush kill and per-unit saturating grant counters.
module cdb_grant_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end
endmodule

module cdb_arbiter #(
    parameter type T      = logic [31:0],
    parameter int  N_FU   = 3,
    parameter int  PREG_W = 7,
    parameter int  ROB_W  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [SRC_W-1:0]      last;
    logic [SRC_W-1:0]      win_idx;
    logic [SRC_W-1:0]      idx;
    logic                  win_any;
    logic [N_FU-1:0]       grant;
    logic                  hs;
    logic [N_FU-1:0][15:0] cnt;

    // Scan last+1 .. last (mod N_FU); first valid unit wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 1; k <= N_FU; k++) begin
            idx = SRC_W'((int'(last) + k) % N_FU);
            if (!win_any && bus.req_valid[idx]) begin
                win_any = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign hs            = win_any & ~flush;
    assign grant         = hs ? (N_FU'(1) << win_idx) : '0;
    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last             <= SRC_W'(N_FU - 1);
            bus.cdb_valid    <= 1'b0;
            bus.cdb_prd      <= '0;
            bus.cdb_rob_tag  <= '0;
            bus.cdb_data     <= '0;
            bus.cdb_regwrite <= 1'b0;
            bus.cdb_src      <= '0;
        end else begin
            bus.cdb_valid <= hs;
            // Payload holds when idle; it is only meaningful under cdb_valid.
            if (hs) begin
                last             <= win_idx;
                bus.cdb_prd      <= bus.req_prd[win_idx];
                bus.cdb_rob_tag  <= bus.req_rob_tag[win_idx];
                bus.cdb_data     <= T'(bus.req_data[win_idx]);
                bus.cdb_regwrite <= bus.req_regwrite[win_idx] &
                                    (bus.req_prd[win_idx] != '0);
                bus.cdb_src      <= win_idx;
            end
        end
    end

    for (genvar i = 0; i < N_FU; i++) begin : g_ctr
        logic [15:0] cnt_q;
        cdb_grant_ctr #(.W(16)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (grant[i]),
            .count (cnt_q)
        );
        assign cnt[i] = cnt_q;
    end

    assign bus.grant_count = cnt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a distance-based
// round-robin reference model.
module tb_cdb_arbiter;
    localparam int N_FU   = 3;
    localparam int PREG_W = 7;
    localparam int ROB_W  = 4;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_FU(N_FU), .PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

    cdb_arbiter #(.N_FU(N_FU), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    bit           m_known = 1'b0;
    int           m_last;
    int           m_cnt [N_FU];
    bit           e_valid;
    bit           e_rst;
    logic [6:0]   e_prd;
    logic [3:0]   e_rob;
    logic [31:0]  e_data;
    bit           e_rw;
    int           e_src;
    int           last_win;

    bit           pend  [N_FU];
    int           waitc [N_FU];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = valid unit at the smallest forward distance past the last grant.
    function automatic int model_win(input logic [N_FU-1:0] v, input int last);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N_FU + 1;
        for (int i = 0; i < N_FU; i++) begin
            d = (i - last - 1 + 2 * N_FU) % N_FU;
            if (v[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic set_req(input int i, input int prd, input int rob, input logic [31:0] data, input bit rw);
        bus.req_valid[i]    = 1'b1;
        bus.req_prd[i]      = PREG_W'(prd);
        bus.req_rob_tag[i]  = ROB_W'(rob);
        bus.req_data[i]     = data;
        bus.req_regwrite[i] = rw;
    endtask

    task automatic clr_req();
        bus.req_valid    = '0;
        bus.req_prd      = '0;
        bus.req_rob_tag  = '0;
        bus.req_data     = '0;
        bus.req_regwrite = '0;
    endtask

    // One clock: inputs already driven at the falling edge; grant checked
    // before the rising edge, registered outputs checked at the next fall.
    task automatic cycle(input bit rst_i, input bit fl_i);
        int              w;
        logic [N_FU-1:0] er;
        reset = rst_i;
        flush = fl_i;
        #1;
        w  = model_win(bus.req_valid, m_last);
        er = '0;
        if (w >= 0 && !fl_i) er[w] = 1'b1;
        if (m_known) chk("req_ready", bus.req_ready, er);
        @(posedge clk);
        last_win = -1;
        if (rst_i) begin
            m_known = 1'b1;
            m_last  = N_FU - 1;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            e_valid = 1'b0;
            e_rst   = 1'b1;
            e_prd   = '0;
            e_rob   = '0;
            e_data  = '0;
            e_rw    = 1'b0;
            e_src   = 0;
        end else begin
            e_rst   = 1'b0;
            e_valid = (er != '0);
            if (e_valid) begin
                e_prd    = bus.req_prd[w];
                e_rob    = bus.req_rob_tag[w];
                e_data   = bus.req_data[w];
                e_rw     = bus.req_regwrite[w] && (bus.req_prd[w] != 0);
                e_src    = w;
                m_last   = w;
                last_win = w;
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end
        end
        @(negedge clk);
        if (m_known) begin
            chk("cdb_valid", bus.cdb_valid, e_valid);
            if (e_valid || e_rst) begin
                chk("cdb_prd", bus.cdb_prd, e_prd);
                chk("cdb_rob_tag", bus.cdb_rob_tag, e_rob);
                chk("cdb_data", bus.cdb_data, e_data);
                chk("cdb_regwrite", bus.cdb_regwrite, e_rw);
                chk("cdb_src", bus.cdb_src, e_src);
            end
            for (int i = 0; i < N_FU; i++)
                chk("grant_count", bus.grant_count[i], m_cnt[i]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl;
        bit rs;
        reset = 1'b1;
        flush = 1'b0;
        clr_req();
        foreach (pend[i]) begin pend[i] = 1'b0; waitc[i] = 0; end

        // Reset and idle
        cycle(1, 0);
        cycle(1, 0);
        repeat (3) cycle(0, 0);

        // All three valid: strict rotation 0,1,2,0,1,2
        set_req(0, 5, 1, 32'h0000_0100, 1'b1);
        set_req(1, 6, 2, 32'h0000_0200, 1'b1);
        set_req(2, 7, 3, 32'h0000_0300, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0);
            chk("rr_src", bus.cdb_src, k % 3);
            chk("rr_prd", bus.cdb_prd, 5 + k % 3);
        end
        for (int i = 0; i < N_FU; i++) chk("rr_count", bus.grant_count[i], 2);

        // Single unit 2, one cycle
        clr_req();
        cycle(1, 0);
        set_req(2, 9, 4, 32'hDEAD_BEEF, 1'b1);
        cycle(0, 0);
        clr_req();
        chk("u2_valid", bus.cdb_valid, 1);
        chk("u2_prd", bus.cdb_prd, 9);
        chk("u2_data", bus.cdb_data, 32'hDEAD_BEEF);
        chk("u2_regwrite", bus.cdb_regwrite, 1);
        chk("u2_src", bus.cdb_src, 2);
        cycle(0, 0);
        chk("u2_idle", bus.cdb_valid, 0);

        // p0 destination: broadcast but no register write
        set_req(0, 0, 5, 32'h0000_1234, 1'b1);
        cycle(0, 0);
        clr_req();
        chk("p0_valid", bus.cdb_valid, 1);
        chk("p0_regwrite", bus.cdb_regwrite, 0);

        // Flush with 011 pending, last grant was unit 0
        set_req(0, 11, 6, 32'h0000_0011, 1'b1);
        set_req(1, 12, 7, 32'h0000_0012, 1'b1);
        cycle(0, 1);
        chk("flush_valid", bus.cdb_valid, 0);
        cycle(0, 0);
        chk("post_flush_src", bus.cdb_src, 1);
        clr_req();

        // Randomized traffic with occasional flush and mid-stream reset
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N_FU; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127)),
                            int'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
                    pend[i]  = 1'b1;
                    waitc[i] = 0;
                end
            end
            fl = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 99) == 0);
            cycle(rs, fl);
            if (last_win >= 0) begin
                chk("fairness", waitc[last_win] < N_FU, 1);
                pend[last_win] = 1'b0;
                bus.req_valid[last_win] = 1'b0;
            end
            for (int i = 0; i < N_FU; i++) if (pend[i]) waitc[i]++;
            if (fl || rs) begin
                foreach (pend[i]) pend[i] = 1'b0;
                clr_req();
            end
        end

        // Counter saturation on unit 1 alone
        clr_req();
        cycle(1, 0);
        set_req(1, 3, 1, 32'h0000_00A5, 1'b1);
        repeat (65540) cycle(0, 0);
        chk("sat_gc1", bus.grant_count[1], 16'hFFFF);
        chk("sat_gc0", bus.grant_count[0], 0);
        chk("sat_gc2", bus.grant_count[2], 0);
        clr_req();
        cycle(0, 0);
        chk("sat_hold", bus.grant_count[1], 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter between the execution units (ALU, branch, LSU) and the single common data bus (CDB). Each cycle it grants at most one completing functional unit using round-robin priority, and registers that unit's result onto the CDB. The CDB feeds reservation-station wakeup, the physical register file write port and ROB completion. The arbiter also kills in-flight results on a pipeline flush and keeps per-unit grant counters for performance analysis.

## Interface
- T, logic [31:0], result data type
- N_FU, 3, number of requesters (0 = ALU, 1 = branch, 2 = LSU)
- PREG_W, 7, physical register tag width
- ROB_W, 4, ROB tag width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  branch-mispredict flush; drops the current grant and the output register
- req_valid  in  N_FU  unit i has a completed result
- req_ready  out  N_FU  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- req_prd  in  N_FU x PREG_W  destination physical register per unit
- req_rob_tag  in  N_FU x ROB_W  ROB entry per unit
- req_data  in  N_FU x $bits(T)  result value per unit
- req_regwrite  in  N_FU  result writes the register file
- cdb_valid  out  1  broadcast valid
- cdb_prd  out  PREG_W  broadcast physical destination
- cdb_rob_tag  out  ROB_W  broadcast ROB tag
- cdb_data  out  $bits(T)  broadcast value
- cdb_regwrite  out  1  register file write enable
- cdb_src  out  2  index of the unit that produced the broadcast
- grant_count  out  N_FU x 16  saturating count of grants per unit

## Operation
- Round-robin pointer `last` (2 bits) holds the index of the most recent grant.
  - Search order: last+1, last+2, …, last, each index taken mod N_FU.
  - The first index in that order with req_valid set wins.
- Grant is combinational: req_ready = one-hot of the winner. req_ready is all-zero when no unit is valid or flush=1.
- Requesters must hold valid and payload stable until they see ready. A unit may depend on its own ready combinationally, but valid must not depend on ready.
- On a handshake:
  - The output register loads the winner's prd, rob_tag, data and regwrite. cdb_src loads the winner's index.
  - `last` updates to the winner.
  - grant_count[winner] increments, saturating at 16'hFFFF.
- With no handshake, cdb_valid clears next cycle. The payload registers hold their old value; their contents are don't-care while cdb_valid=0.
- cdb_regwrite = req_regwrite & (req_prd != 0). Physical register p0 is never written. cdb_valid is still asserted for a p0 result so the ROB sees the completion.
- The CDB has no backpressure. Every broadcast is consumed in its cycle.
- flush:
  - Suppresses the grant in the same cycle.
  - Clears cdb_valid on the next edge.
  - Leaves `last` and grant_count unchanged.
  - Requesters are expected to drop their own valids. The arbiter does not track tags.
- Reset:
  - cdb_valid=0, cdb_regwrite=0, cdb_prd=0, cdb_rob_tag=0, cdb_data=0, cdb_src=0.
  - All grant_count=0.
  - last=N_FU-1, so unit 0 has first priority.
  - reset takes precedence over flush and over a concurrent handshake.

## Timing
- Latency is 1 cycle: a handshake at edge N produces cdb_valid high for the cycle after edge N, carrying that payload.
- Back-to-back grants give one broadcast per cycle, every cycle.
- Fairness: a unit holding valid continuously is granted within N_FU cycles.
- With a single persistent requester, that unit is granted every cycle.
- flush and a valid request in the same cycle: no handshake occurs and cdb_valid=0 next cycle.
- Reset asserted mid-stream: outputs take reset values on the next edge regardless of the requests.
- grant_count at 16'hFFFF stays there after further grants. The other counters are unaffected.

## Test plan
- Reset, then hold req_valid=3'b000 → cdb_valid=0 and req_ready=0 every cycle; grant_count all 0.
- After reset, req_valid=3'b111 held with distinct tags (prd 5/6/7) → grants go to units 0,1,2,0,1,2.
  - cdb_src follows the same sequence one cycle later, with the matching cdb_prd.
  - After 6 cycles each grant_count=2.
- Only unit 2 valid (prd=9, data=32'hDEADBEEF, regwrite=1) for one cycle → next cycle cdb_valid=1, cdb_prd=9, cdb_data=32'hDEADBEEF, cdb_regwrite=1, cdb_src=2. The cycle after, cdb_valid=0.
- Unit 0 valid with prd=0, regwrite=1 → cdb_valid=1 and cdb_regwrite=0.
- req_valid=3'b011 with flush=1 in the same cycle → req_ready=0 and cdb_valid=0 next cycle.
  - After flush drops, the next grant goes to the unit following the pre-flush `last`.
- Force grant_count[1] to the saturation value by 65,540 grants to unit 1 alone → grant_count[1]=16'hFFFF and holds there; grant_count[0] and grant_count[2] stay 0.
